// File: rtl/gearbox_16to10.sv
// gearbox_16to10: LSB-first stream width converter, IN_W-bit words in, OUT_W-bit words out.
// A packet end flushes residual bits as one zero-padded final word flagged with out_last.
module gearbox_16to10 #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int ACC_W = IN_W + OUT_W - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_last_q, pend_last_d;
    logic             in_fire;
    logic             out_fire;

    // All handshake outputs are pure functions of registered state, so there is
    // no combinational path from in_valid or out_ready to anything.
    assign in_ready  = !pend_last_q && (cnt_q < OUT_CNT);
    assign out_valid = (cnt_q >= OUT_CNT) || (pend_last_q && (cnt_q != '0));
    assign out_last  = pend_last_q && (cnt_q <= OUT_CNT) && (cnt_q != '0);
    assign out_data  = acc_q[OUT_W-1:0];

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pend_last_d = pend_last_q;
        if (in_fire) begin
            // cnt < OUT_W here, so the shifted word always fits in ACC_W bits
            acc_d       = acc_q | (ACC_W'(in_data) << cnt_q);
            cnt_d       = cnt_q + IN_CNT;
            pend_last_d = in_last;
        end else if (out_fire) begin
            if (out_last) begin
                acc_d       = '0;
                cnt_d       = '0;
                pend_last_d = 1'b0;
            end else begin
                acc_d = acc_q >> OUT_W;
                cnt_d = cnt_q - OUT_CNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            pend_last_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_last_q <= pend_last_d;
        end
    end

endmodule

// File: tb/tb_gearbox_16to10.sv
// Directed and randomized bench for gearbox_16to10 against a bit-queue reference model.
module tb_gearbox_16to10;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } in_t;

    typedef struct packed {
        logic       last;
        logic [9:0] data;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [9:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    in_t  in_q[$];
    out_t exp_q[$];

    always #5 clk = ~clk;

    gearbox_16to10 dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        rst_b = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(input logic [9:0] exp_d, input logic exp_l, input string tag);
        int n = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_last"}, out_last, exp_l);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Reference: a packet is one long LSB-first bit string cut into 10-bit
    // pieces; the final piece is zero-padded and carries the last flag.
    task automatic add_packet(input int nwords);
        bit   bits[$];
        in_t  w;
        out_t e;
        for (int i = 0; i < nwords; i++) begin
            w.data = 16'($urandom);
            w.last = (i == nwords - 1);
            in_q.push_back(w);
            for (int b = 0; b < 16; b++) bits.push_back(w.data[b]);
        end
        while (bits.size() > 0) begin
            e.data = '0;
            for (int b = 0; b < 10; b++)
                if (bits.size() > 0) e.data[b] = bits.pop_front();
            e.last = (bits.size() == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_stream(input int ready_pct, input int max_cycles, input string tag);
        int         cyc = 0;
        logic       held = 1'b0;
        logic       in_hold = 1'b0;
        logic [9:0] held_d = '0;
        logic       held_l = 1'b0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                chk({tag, "_stall_valid"}, out_valid, 1);
                chk({tag, "_stall_data"}, out_data, held_d);
                chk({tag, "_stall_last"}, out_last, held_l);
            end
            if (in_q.size() > 0 && (in_hold || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = in_q[0].data;
                in_last  = in_q[0].last;
            end else begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_last  = 1'b0;
            end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_out"}, 1, 0);
                end else begin
                    chk({tag, "_data"}, out_data, exp_q[0].data);
                    chk({tag, "_last"}, out_last, exp_q[0].last);
                    void'(exp_q.pop_front());
                end
                held = 1'b0;
            end else begin
                held = out_valid;
            end
            held_d  = out_data;
            held_l  = out_last;
            in_hold = in_valid && !in_ready;
            if (in_valid && in_ready) void'(in_q.pop_front());
        end
        chk({tag, "_all_consumed"}, 32'(exp_q.size() + in_q.size()), 0);
        in_q.delete();
        exp_q.delete();
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_no_extra"}, out_valid, 0);
        end
        out_ready = 1'b0;
    endtask

    task automatic scenario_abcd(input string tag);
        send(16'hABCD, 1'b1);
        chk({tag, "_in_ready_flush"}, in_ready, 0);
        recv(10'h3CD, 1'b0, {tag, "_w0"});
        chk({tag, "_in_ready_flush2"}, in_ready, 0);
        recv(10'h02A, 1'b1, {tag, "_w1"});
        @(negedge clk);
        chk({tag, "_idle_in_ready"}, in_ready, 1);
        chk({tag, "_idle_out_valid"}, out_valid, 0);
    endtask

    initial begin
        in_t  w;
        out_t e;
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        do_reset();
        scenario_abcd("s1");

        send(16'h1234, 1'b0);
        recv(10'h234, 1'b0, "s2_w0");
        send(16'h5678, 1'b0);
        recv(10'h204, 1'b0, "s2_w1");
        recv(10'h167, 1'b0, "s2_w2");
        @(negedge clk);
        chk("s2_resid_out_valid", out_valid, 0);
        chk("s2_resid_in_ready", in_ready, 1);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            w.data = 16'hFFFF;
            w.last = (i == 4);
            in_q.push_back(w);
        end
        for (int i = 0; i < 8; i++) begin
            e.data = 10'h3FF;
            e.last = (i == 7);
            exp_q.push_back(e);
        end
        run_stream(100, 200, "s3");

        send(16'hABCD, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s4_hold_valid", out_valid, 1);
            chk("s4_hold_data", out_data, 10'h3CD);
            chk("s4_hold_last", out_last, 0);
            chk("s4_hold_in_ready", in_ready, 0);
        end
        recv(10'h3CD, 1'b0, "s4_w0");
        recv(10'h02A, 1'b1, "s4_w1");
        @(negedge clk);
        chk("s4_idle_out_valid", out_valid, 0);

        send(16'h1234, 1'b0);
        recv(10'h234, 1'b0, "s5_w0");
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        chk("s5_async_out_valid", out_valid, 0);
        chk("s5_async_out_data", out_data, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("s5_post_in_ready", in_ready, 1);
        chk("s5_post_out_valid", out_valid, 0);
        scenario_abcd("s5r");

        for (int p = 0; p < 40; p++) add_packet(int'($urandom_range(1, 6)));
        run_stream(60, 20000, "rnd");

        for (int p = 0; p < 20; p++) add_packet(int'($urandom_range(1, 3)));
        run_stream(95, 10000, "rnd_fast");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
